// File: rtl/integral_pkg.sv
// Shared definitions for the integral-image writer and the box-sum reader:
// default geometry, table word width and FSM state encoding.
package integral_pkg;

  localparam int IMG_W_DEF   = 4;
  localparam int IMG_H_DEF   = 4;
  localparam int INT_W_DEF   = 8;
  localparam int COORD_W_DEF = 2;
  localparam int ADDR_W      = 8;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] RD_ADDR = 3'd1;
  localparam logic [STATE_W-1:0] RD_WAIT = 3'd2;
  localparam logic [STATE_W-1:0] RD_CAP  = 3'd3;
  localparam logic [STATE_W-1:0] RESULT  = 3'd4;

  // Returns {found, index} of the lowest enabled term strictly after cur.
  function automatic logic [2:0] next_term(input logic [3:0] mask, input logic [1:0] cur);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if ((i > int'(cur)) && mask[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/integral_box_sum.sv
// Rectangle sum over a precomputed integral table: up to four reads, each taking
// an address/wait/capture slot, combined with inclusion-exclusion signs.
module integral_box_sum
  import integral_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int INT_W   = INT_W_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      int_ready,
  input  logic                      query_valid,
  output logic                      query_ready,
  input  logic [COORD_W-1:0]        q_x0,
  input  logic [COORD_W-1:0]        q_y0,
  input  logic [COORD_W-1:0]        q_x1,
  input  logic [COORD_W-1:0]        q_y1,
  output logic [ADDR_W-1:0]         M10K_read_address_int,
  input  logic signed [INT_W-1:0]   M10K_read_data_int,
  output logic                      sum_valid,
  input  logic                      sum_ready,
  output logic signed [INT_W+1:0]   box_sum,
  output logic                      err
);

  localparam int SUM_W = INT_W + 2;

  logic [STATE_W-1:0]      state_q, state_d;
  logic [COORD_W-1:0]      x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [3:0]              mask_q, mask_d;
  logic [1:0]              term_q, term_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic signed [SUM_W-1:0] acc_q, acc_d;
  logic signed [SUM_W-1:0] box_sum_q, box_sum_d;
  logic                    sum_valid_q, sum_valid_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    q_bad;
  logic [3:0]              q_mask;
  logic [2:0]              nxt;
  logic signed [SUM_W-1:0] term_ext;
  logic signed [SUM_W-1:0] acc_upd;

  // Term index bit 0 selects row y0-1 instead of y1, bit 1 selects column x0-1 instead of x1.
  function automatic logic [ADDR_W-1:0] term_addr(input logic [1:0] t,
                                                  input logic [COORD_W-1:0] x0,
                                                  input logic [COORD_W-1:0] y0,
                                                  input logic [COORD_W-1:0] x1,
                                                  input logic [COORD_W-1:0] y1);
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] c;
    r = t[0] ? (ADDR_W'(y0) - ADDR_W'(1)) : ADDR_W'(y1);
    c = t[1] ? (ADDR_W'(x0) - ADDR_W'(1)) : ADDR_W'(x1);
    return ADDR_W'(r * ADDR_W'(IMG_W)) + c;
  endfunction

  always_comb begin
    query_ready = (state_q == IDLE) && int_ready;
    accept      = query_valid && query_ready;
    q_bad       = (q_x0 > q_x1) || (q_y0 > q_y1) ||
                  (int'(q_x1) >= IMG_W) || (int'(q_y1) >= IMG_H);
    q_mask      = {(q_y0 != '0) && (q_x0 != '0), (q_x0 != '0), (q_y0 != '0), 1'b1};
    nxt         = next_term(mask_q, term_q);
    term_ext    = {{2{M10K_read_data_int[INT_W-1]}}, M10K_read_data_int};
    // The two single-corner-shifted terms are subtracted, the rest added.
    acc_upd     = (term_q[0] ^ term_q[1]) ? (acc_q - term_ext) : (acc_q + term_ext);
  end

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    mask_d      = mask_q;
    term_d      = term_q;
    addr_d      = addr_q;
    acc_d       = acc_q;
    box_sum_d   = box_sum_q;
    sum_valid_d = sum_valid_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          x0_d   = q_x0;
          y0_d   = q_y0;
          x1_d   = q_x1;
          y1_d   = q_y1;
          mask_d = q_mask;
          term_d = 2'd0;
          acc_d  = '0;
          if (q_bad) begin
            state_d     = RESULT;
            sum_valid_d = 1'b1;
            err_d       = 1'b1;
            box_sum_d   = '0;
          end else begin
            state_d = RD_ADDR;
            addr_d  = term_addr(2'd0, q_x0, q_y0, q_x1, q_y1);
          end
        end
      end
      RD_ADDR: state_d = RD_WAIT;
      RD_WAIT: state_d = RD_CAP;
      RD_CAP: begin
        acc_d = acc_upd;
        if (nxt[2]) begin
          state_d = RD_ADDR;
          term_d  = nxt[1:0];
          addr_d  = term_addr(nxt[1:0], x0_q, y0_q, x1_q, y1_q);
        end else begin
          state_d     = RESULT;
          sum_valid_d = 1'b1;
          box_sum_d   = acc_upd;
          err_d       = 1'b0;
        end
      end
      RESULT: begin
        if (sum_ready) begin
          state_d     = IDLE;
          sum_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      mask_q      <= '0;
      term_q      <= '0;
      addr_q      <= '0;
      acc_q       <= '0;
      box_sum_q   <= '0;
      sum_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      mask_q      <= mask_d;
      term_q      <= term_d;
      addr_q      <= addr_d;
      acc_q       <= acc_d;
      box_sum_q   <= box_sum_d;
      sum_valid_q <= sum_valid_d;
      err_q       <= err_d;
    end
  end

  assign M10K_read_address_int = addr_q;
  assign sum_valid             = sum_valid_q;
  assign box_sum               = box_sum_q;
  assign err                   = err_q;

endmodule
